// File: rtl/cstrip_pkg.sv
// cstrip_pkg: shared state encoding and character constants for comment_strip and char_class.
// Block-comment support follows the COMMENT_STRIP_BLOCK_EN macro.
package cstrip_pkg;
    typedef enum logic [2:0] {NORM, SLASH, LINE, BLOCK, BSTAR} state_t;
    localparam logic [7:0] CH_SP    = 8'h20;
    localparam logic [7:0] CH_TAB   = 8'h09;
    localparam logic [7:0] CH_LF    = 8'h0a;
    localparam logic [7:0] CH_CR    = 8'h0d;
    localparam logic [7:0] CH_SLASH = 8'h2f;
    localparam logic [7:0] CH_STAR  = 8'h2a;
`ifdef COMMENT_STRIP_BLOCK_EN
    localparam bit BLOCK_EN = 1'b1;
`else
    localparam bit BLOCK_EN = 1'b0;
`endif
endpackage

// File: rtl/char_class.sv
// char_class: combinational classifier of one ASCII byte (whitespace, slash, star, line feed).
module char_class
    import cstrip_pkg::*;
(
    input  logic [7:0] in,
    output logic       is_ws,
    output logic       is_slash,
    output logic       is_star,
    output logic       is_lf
);
    assign is_ws    = (in == CH_SP) || (in == CH_TAB) || (in == CH_LF) || (in == CH_CR);
    assign is_slash = in == CH_SLASH;
    assign is_star  = in == CH_STAR;
    assign is_lf    = in == CH_LF;
endmodule

// File: rtl/comment_strip.sv
// comment_strip: strips // and /* */ comments and collapses whitespace, one byte per cycle.
// Block comments are recognised only when COMMENT_STRIP_BLOCK_EN is defined.
module comment_strip
    import cstrip_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic       in_valid,
    input  logic [7:0] in,
    output logic       in_ready,
    output logic       out_valid,
    output logic [7:0] out
);
    state_t     state;
    logic       last_sp;
    logic       pend_valid;
    logic [7:0] pend_ch;
    logic [7:0] ch;
    logic       act;
    logic       is_ws, is_slash, is_star, is_lf;

    // The character that follows a non-comment slash is replayed from the pending buffer.
    assign ch  = pend_valid ? pend_ch : in;
    assign act = pend_valid || (in_valid && in_ready);

    char_class u_class (
        .in       (ch),
        .is_ws    (is_ws),
        .is_slash (is_slash),
        .is_star  (is_star),
        .is_lf    (is_lf)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= NORM;
            last_sp    <= 1'b1;
            pend_valid <= 1'b0;
            pend_ch    <= 8'h00;
            in_ready   <= 1'b1;
            out_valid  <= 1'b0;
            out        <= 8'h00;
        end else begin
            out_valid <= 1'b0;
            if (pend_valid) begin
                pend_valid <= 1'b0;
                in_ready   <= 1'b1;
            end
            if (act) begin
                case (state)
                    NORM: begin
                        if (is_slash) begin
                            state <= SLASH;
                        end else if (is_ws) begin
                            if (!last_sp) begin
                                out       <= CH_SP;
                                out_valid <= 1'b1;
                                last_sp   <= 1'b1;
                            end
                        end else begin
                            out       <= ch;
                            out_valid <= 1'b1;
                            last_sp   <= 1'b0;
                        end
                    end
                    SLASH: begin
                        if (is_slash) begin
                            state <= LINE;
                        end else if (is_star && BLOCK_EN) begin
                            state <= BLOCK;
                        end else begin
                            out        <= CH_SLASH;
                            out_valid  <= 1'b1;
                            last_sp    <= 1'b0;
                            pend_valid <= 1'b1;
                            pend_ch    <= ch;
                            in_ready   <= 1'b0;
                            state      <= NORM;
                        end
                    end
                    LINE: begin
                        if (is_lf) begin
                            state <= NORM;
                            if (!last_sp) begin
                                out       <= CH_SP;
                                out_valid <= 1'b1;
                                last_sp   <= 1'b1;
                            end
                        end
                    end
`ifdef COMMENT_STRIP_BLOCK_EN
                    BLOCK: begin
                        if (is_star) state <= BSTAR;
                    end
                    BSTAR: begin
                        if (is_slash) begin
                            state <= NORM;
                            if (!last_sp) begin
                                out       <= CH_SP;
                                out_valid <= 1'b1;
                                last_sp   <= 1'b1;
                            end
                        end else if (!is_star) begin
                            state <= BLOCK;
                        end
                    end
`endif
                    default: state <= NORM;
                endcase
            end
        end
    end
endmodule
